// File: rtl/inst_fetch.sv
// Instruction fetch stage of the multicycle MIPS core.
// Issues a request/acknowledge read for the address held in the PC register,
// captures the returned word in IR, and when decode consumes it computes the
// next PC and pulses PCWre for one cycle. Illegal fetch addresses halt the
// stage until reset.
module inst_fetch #(
  parameter logic [31:0] INIT_ADDR = 32'h00400000,
  parameter logic [31:0] END_ADDR  = 32'h00405000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] currentIAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] nextIAddr,
  output logic        PCWre,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT   = 3'd1,
    HOLD   = 3'd2,
    UPDATE = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        addr_bad;
  logic        req_d;
  logic [31:0] addr_d;
  logic [31:0] ir_d;
  logic        irv_d;
  logic        pcwre_d;
  logic [31:0] nia_d;
  logic        err_d;

  // Next PC: jump beats branch, otherwise sequential (wraps mod 2^32).
  function automatic logic [31:0] calc_next(
    input logic [31:0] pc,
    input logic        br,
    input logic [31:0] tgt,
    input logic        jmp,
    input logic [25:0] idx
  );
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    if (jmp)
      calc_next = {pc4[31:28], idx, 2'b00};
    else if (br)
      calc_next = tgt;
    else
      calc_next = pc4;
  endfunction

  assign addr_bad = (currentIAddr >= END_ADDR) || (currentIAddr[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)
      state_q <= FETCH;
    else
      state_q <= state_d;
  end

  // Next-state logic; inputs outside their owning state are don't-care.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = addr_bad ? HALT : WAIT;
      WAIT:    if (imem_ack) state_d = HOLD;
      HOLD:    if (advance)  state_d = UPDATE;
      UPDATE:  state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Output/datapath next values; PCWre defaults low so it can only pulse.
  always_comb begin
    req_d   = imem_req;
    addr_d  = imem_addr;
    ir_d    = IR;
    irv_d   = ir_valid;
    pcwre_d = 1'b0;
    nia_d   = nextIAddr;
    err_d   = fetch_err;
    case (state_q)
      FETCH: begin
        if (addr_bad) begin
          err_d = 1'b1;
        end else begin
          req_d  = 1'b1;
          addr_d = currentIAddr;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          ir_d  = imem_rdata;
          irv_d = 1'b1;
          req_d = 1'b0;
        end
      end
      HOLD: begin
        if (advance) begin
          nia_d   = calc_next(currentIAddr, branch_taken, branch_target,
                              jump, jump_index);
          pcwre_d = 1'b1;
          irv_d   = 1'b0;
        end
      end
      UPDATE: begin
        pcwre_d = 1'b0;
      end
      HALT: begin
        req_d = 1'b0;
        err_d = 1'b1;
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset takes effect immediately, even mid-request.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
      IR        <= 32'd0;
      ir_valid  <= 1'b0;
      PCWre     <= 1'b0;
      nextIAddr <= INIT_ADDR;
      fetch_err <= 1'b0;
    end else begin
      imem_req  <= req_d;
      imem_addr <= addr_d;
      IR        <= ir_d;
      ir_valid  <= irv_d;
      PCWre     <= pcwre_d;
      nextIAddr <= nia_d;
      fetch_err <= err_d;
    end
  end

endmodule
